// File: rtl/ws2812_pkg.sv
// Shared ws2812 timing constants, scheduler state encoding and pixel layout.
// Pure declarations: no latency and no flow control.
package ws2812_pkg;

   localparam int unsigned CYCLES_0_HIGH = 20;
   localparam int unsigned CYCLES_1_HIGH = 40;
   localparam int unsigned CYCLES_BIT    = 63;
   localparam int unsigned CYCLES_RESET  = 2600;
   localparam int unsigned ADDR_W        = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      GAP  = 2'd2
   } sched_state_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   // Whole-frame serializer cycle count, evaluated at elaboration in 64 bits.
   function automatic longint unsigned frame_cycles(
      input int unsigned led_count,
      input int unsigned cyc_bit   = CYCLES_BIT,
      input int unsigned cyc_reset = CYCLES_RESET
   );
      longint unsigned leds;
      longint unsigned bits;
      longint unsigned rst;
      leds = led_count;
      bits = cyc_bit;
      rst  = cyc_reset;
      return rst + leds * 64'd24 * bits;
   endfunction

endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Host control/pixel-write bus plus serializer-facing reset and pixel lookup.
// Plain level/pulse signals: no latency and no backpressure at this boundary.
interface ws2812_frame_sched_if;
   import ws2812_pkg::*;

   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   pixel_t            wr_data_i;
   logic              swap_req_i;
   logic              start_i;
   logic              continuous_i;
   logic              swap_pending_o;
   logic              front_o;
   logic              busy_o;
   logic              frame_done_o;
   logic              drv_rst_o;
   logic [ADDR_W-1:0] drv_addr_i;
   logic [7:0]        r_o;
   logic [7:0]        g_o;
   logic [7:0]        b_o;

   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, swap_req_i, start_i, continuous_i, drv_addr_i,
      input  swap_pending_o, front_o, busy_o, frame_done_o, drv_rst_o, r_o, g_o, b_o
   );

   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, swap_req_i, start_i, continuous_i, drv_addr_i,
      output swap_pending_o, front_o, busy_o, frame_done_o, drv_rst_o, r_o, g_o, b_o
   );

endinterface

// File: rtl/ws2812_pixel_ram.sv
// Two-bank pixel store: one write port, one registered read port, out-of-range reads give 0.
// Latency 1 cycle write-to-read and address-to-data; never stalls, out-of-range writes are dropped.
module ws2812_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int unsigned LED_COUNT = 256
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wr_en_i,
   input  logic              wr_bank_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  pixel_t            wr_data_i,
   input  logic              rd_bank_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output pixel_t            rd_data_o
);

   localparam int unsigned     IDX_W = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(LED_COUNT);

   pixel_t mem [2][LED_COUNT];

   logic wr_hit;
   logic rd_hit;

   // Range check in one extra bit so LED_COUNT=512 does not wrap to zero.
   assign wr_hit = ({1'b0, wr_addr_i} < LIMIT);
   assign rd_hit = ({1'b0, rd_addr_i} < LIMIT);

   always_ff @(posedge clk_i) begin
      if (wr_en_i && wr_hit) begin
         mem[wr_bank_i][wr_addr_i[IDX_W-1:0]] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_data_o <= '0;
      end else if (rd_hit) begin
         rd_data_o <= mem[rd_bank_i][rd_addr_i[IDX_W-1:0]];
      end else begin
         rd_data_o <= '0;
      end
   end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frames one ws2812 serializer by gating its reset and swaps pixel banks only in the inter-frame gap.
// Start-to-run 1 cycle, run F+1 cycles plus 1 gap cycle; no backpressure, one extra start is latched.
module ws2812_frame_sched
   import ws2812_pkg::*;
#(
   parameter int unsigned LED_COUNT    = 256,
   parameter int unsigned CYCLES_BIT   = ws2812_pkg::CYCLES_BIT,
   parameter int unsigned CYCLES_RESET = ws2812_pkg::CYCLES_RESET
) (
   input logic                  clk_i,
   input logic                  rst_n_i,
   ws2812_frame_sched_if.slave  bus
);

   localparam longint unsigned  FRAME    = frame_cycles(LED_COUNT, CYCLES_BIT, CYCLES_RESET);
   localparam int               CNT_W    = $clog2(FRAME + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   sched_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_flag_q, start_flag_d;
   logic             swap_pend_q, swap_pend_d;
   logic             front_q, front_d;
   pixel_t           rd_px;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         start_flag_q <= 1'b0;
         swap_pend_q  <= 1'b0;
         front_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         start_flag_q <= start_flag_d;
         swap_pend_q  <= swap_pend_d;
         front_q      <= front_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      start_flag_d = start_flag_q;
      swap_pend_d  = swap_pend_q | bus.swap_req_i;
      front_d      = front_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (swap_pend_q) begin
               front_d     = ~front_q;
               swap_pend_d = 1'b0;
            end
            if (bus.start_i || start_flag_q || bus.continuous_i) begin
               state_d      = RUN;
               start_flag_d = 1'b0;
            end
         end
         RUN: begin
            if (bus.start_i) begin
               start_flag_d = 1'b1;
            end
            // Holding RUN through count F lets the serializer's output register finish the last bit.
            if (cnt_q == CNT_LAST) begin
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         GAP: begin
            cnt_d = '0;
            if (swap_pend_q || bus.swap_req_i) begin
               front_d     = ~front_q;
               swap_pend_d = 1'b0;
            end
            if (bus.continuous_i || start_flag_q || bus.start_i) begin
               state_d      = RUN;
               start_flag_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.drv_rst_o      = (state_q != RUN);
   assign bus.busy_o         = (state_q == RUN);
   assign bus.frame_done_o   = (state_q == GAP);
   assign bus.swap_pending_o = swap_pend_q;
   assign bus.front_o        = front_q;

   // Host always writes the hidden bank; the serializer always reads the displayed one.
   ws2812_pixel_ram #(
      .LED_COUNT (LED_COUNT)
   ) u_ram (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_en_i   (bus.wr_en_i),
      .wr_bank_i (~front_q),
      .wr_addr_i (bus.wr_addr_i),
      .wr_data_i (bus.wr_data_i),
      .rd_bank_i (front_q),
      .rd_addr_i (bus.drv_addr_i),
      .rd_data_o (rd_px)
   );

   assign bus.r_o = rd_px.r;
   assign bus.g_o = rd_px.g;
   assign bus.b_o = rd_px.b;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched with LED_COUNT=4 (F = 8648).
module tb_ws2812_frame_sched;

   localparam int F = 8648;

   logic clk = 1'b0;
   logic rst_n;

   ws2812_frame_sched_if bus ();

   ws2812_frame_sched #(
      .LED_COUNT    (4),
      .CYCLES_BIT   (63),
      .CYCLES_RESET (2600)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [23:0] p1 [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
   logic [23:0] p0 [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wr(input int a, input logic [23:0] d);
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = 9'(a);
      bus.wr_data_i = d;
      step();
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int a, input logic [23:0] exp);
      bus.drv_addr_i = 9'(a);
      step();
      chk(tag, 32'({bus.r_o, bus.g_o, bus.b_o}), 32'(exp));
   endtask

   task automatic pulse_start();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
   endtask

   task automatic pulse_swap();
      bus.swap_req_i = 1'b1;
      step();
      bus.swap_req_i = 1'b0;
   endtask

   initial begin
      int n;
      int fd;
      int np;
      int cyc;
      int highs;
      int t [3];

      rst_n            = 1'b0;
      bus.wr_en_i      = 1'b0;
      bus.wr_addr_i    = '0;
      bus.wr_data_i    = '0;
      bus.swap_req_i   = 1'b0;
      bus.start_i      = 1'b0;
      bus.continuous_i = 1'b0;
      bus.drv_addr_i   = '0;
      repeat (3) step();

      chk("rst_drv_rst", 32'(bus.drv_rst_o), 32'd1);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.frame_done_o), 32'd0);
      chk("rst_pend", 32'(bus.swap_pending_o), 32'd0);
      chk("rst_front", 32'(bus.front_o), 32'd0);
      chk("rst_rgb", 32'({bus.r_o, bus.g_o, bus.b_o}), 32'd0);
      rst_n = 1'b1;

      // Fill bank 1 (back), swap in IDLE, fill bank 0, then check bank 1 is displayed.
      for (int i = 0; i < 4; i++) wr(i, p1[i]);
      pulse_swap();
      chk("idle_pend_set", 32'(bus.swap_pending_o), 32'd1);
      chk("idle_front_hold", 32'(bus.front_o), 32'd0);
      step();
      chk("idle_front_swap", 32'(bus.front_o), 32'd1);
      chk("idle_pend_clr", 32'(bus.swap_pending_o), 32'd0);
      for (int i = 0; i < 4; i++) wr(i, p0[i]);
      wr(4, 24'hABCDEF);
      for (int i = 0; i < 4; i++) rd_chk($sformatf("rd_bank1_%0d", i), i, p1[i]);
      rd_chk("rd_oob_7", 7, 24'h0);
      pulse_swap();
      step();
      chk("idle_front_back", 32'(bus.front_o), 32'd0);
      rd_chk("rd_bank0_0_after_oob_wr", 0, p0[0]);
      rd_chk("rd_bank0_3", 3, p0[3]);

      // Single frame.
      pulse_start();
      chk("sf_drv_rst_low", 32'(bus.drv_rst_o), 32'd0);
      chk("sf_busy", 32'(bus.busy_o), 32'd1);
      n  = 0;
      fd = 0;
      while (bus.drv_rst_o == 1'b0 && n < 20000) begin
         n++;
         if (bus.frame_done_o) fd++;
         step();
      end
      chk("sf_run_len", 32'(n), 32'(F + 1));
      chk("sf_done_in_run", 32'(fd), 32'd0);
      chk("sf_gap_done", 32'(bus.frame_done_o), 32'd1);
      chk("sf_gap_busy", 32'(bus.busy_o), 32'd0);
      step();
      chk("sf_idle_done", 32'(bus.frame_done_o), 32'd0);
      chk("sf_idle_busy", 32'(bus.busy_o), 32'd0);
      chk("sf_idle_drv_rst", 32'(bus.drv_rst_o), 32'd1);

      // Swap during RUN plus two latched starts: exactly one extra frame.
      wr(2, 24'hFF0000);
      pulse_start();
      repeat (5) step();
      pulse_swap();
      chk("run_pend_set", 32'(bus.swap_pending_o), 32'd1);
      chk("run_front_hold", 32'(bus.front_o), 32'd0);
      pulse_start();
      step();
      pulse_start();
      n = 0;
      while (bus.drv_rst_o == 1'b0 && n < 20000) begin
         n++;
         step();
      end
      chk("gapA_done", 32'(bus.frame_done_o), 32'd1);
      chk("gapA_front", 32'(bus.front_o), 32'd0);
      chk("gapA_pend", 32'(bus.swap_pending_o), 32'd1);
      step();
      chk("frB_front", 32'(bus.front_o), 32'd1);
      chk("frB_pend", 32'(bus.swap_pending_o), 32'd0);
      chk("frB_busy", 32'(bus.busy_o), 32'd1);
      bus.drv_addr_i = 9'd2;
      step();
      chk("frB_r", 32'(bus.r_o), 32'hFF);
      chk("frB_g", 32'(bus.g_o), 32'h0);
      chk("frB_b", 32'(bus.b_o), 32'h0);
      rd_chk("frB_px3", 3, p1[3]);
      n = 0;
      while (bus.drv_rst_o == 1'b0 && n < 20000) begin
         n++;
         step();
      end
      chk("gapB_done", 32'(bus.frame_done_o), 32'd1);
      step();
      chk("after_B_busy", 32'(bus.busy_o), 32'd0);
      repeat (5) step();
      chk("no_third_frame", 32'(bus.busy_o), 32'd0);

      // Continuous mode: three frames, drop the level partway through the third.
      bus.continuous_i = 1'b1;
      np    = 0;
      cyc   = 0;
      highs = 0;
      t     = '{0, 0, 0};
      while (np < 3 && cyc < 40000) begin
         step();
         cyc++;
         if (bus.frame_done_o) begin
            t[np] = cyc;
            np++;
         end
         if (np >= 1 && np < 3 && bus.drv_rst_o) highs++;
         if (np == 2 && cyc > t[1] + 10) bus.continuous_i = 1'b0;
      end
      bus.continuous_i = 1'b0;
      chk("cont_pulses", 32'(np), 32'd3);
      chk("cont_period1", 32'(t[1] - t[0]), 32'(F + 2));
      chk("cont_period2", 32'(t[2] - t[1]), 32'(F + 2));
      chk("cont_gap_len", 32'(highs), 32'd2);
      step();
      chk("cont_end_idle", 32'(bus.busy_o), 32'd0);

      // Reset at RUN count 1000 with a swap pending.
      pulse_start();
      pulse_swap();
      repeat (999) step();
      chk("mid_pend_before", 32'(bus.swap_pending_o), 32'd1);
      rst_n = 1'b0;
      step();
      chk("mid_drv_rst", 32'(bus.drv_rst_o), 32'd1);
      chk("mid_busy", 32'(bus.busy_o), 32'd0);
      chk("mid_done", 32'(bus.frame_done_o), 32'd0);
      chk("mid_pend", 32'(bus.swap_pending_o), 32'd0);
      chk("mid_front", 32'(bus.front_o), 32'd0);
      rst_n = 1'b1;
      fd = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.frame_done_o) fd++;
         step();
      end
      chk("mid_no_done", 32'(fd), 32'd0);
      chk("mid_stays_idle", 32'(bus.busy_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
